// File: rtl/fpu_mul_arbiter.sv
// rtl/fpu_mul_arbiter.sv - two-requester round-robin front end for one shared FP multiplier
// Optional WAIT watchdog enabled by defining FPU_MUL_ARB_TIMEOUT_EN.
module fpu_mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int E       = 8,
    parameter int F       = 23,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               mul_start,
    input  logic               mul_busy,
    output logic [WIDTH:0]     mul_a,
    output logic [WIDTH:0]     mul_b,
    input  logic [E+F+1:0]     mul_r,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic               res_s,
    output logic [E-1:0]       res_e,
    output logic [F:0]         res_f,
    output logic               res_err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t           state;
    logic             rr_ptr;
    logic             gnt;
    logic             seen_busy;
    logic             grant_sel;
    logic             mul_done;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Expand to {sign, exp, hidden, frac}; zero exponent means no hidden one.
    function automatic logic [WIDTH:0] unpack(input logic [WIDTH-1:0] op);
        return {op[WIDTH-1], op[F +: E], (op[F +: E] != '0), op[F-1:0]};
    endfunction

    always_comb begin
        grant_sel = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    end

    assign sel_a     = grant_sel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    assign sel_b     = grant_sel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    assign mul_done  = seen_busy && !mul_busy;
    assign req_ready = (rst_n && state == IDLE && req_valid != 2'b00)
                       ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gnt       <= 1'b0;
            seen_busy <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_s     <= 1'b0;
            res_e     <= '0;
            res_f     <= '0;
`ifdef FPU_MUL_ARB_TIMEOUT_EN
            res_err   <= 1'b0;
            wcnt      <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        gnt       <= grant_sel;
                        rr_ptr    <= ~grant_sel;
                        mul_a     <= unpack(sel_a);
                        mul_b     <= unpack(sel_b);
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    seen_busy <= 1'b0;
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                    wcnt      <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mul_busy) seen_busy <= 1'b1;
                    if (mul_done) begin
                        res_s     <= mul_r[E+F+1];
                        res_e     <= mul_r[F+1 +: E];
                        res_f     <= mul_r[F:0];
                        res_id    <= gnt;
                        res_valid <= 1'b1;
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                        state     <= HOLD;
                    end
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                    else if (wcnt == CW'(TIMEOUT - 1)) begin
                        res_s     <= 1'b0;
                        res_e     <= '0;
                        res_f     <= '0;
                        res_id    <= gnt;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb/tb_fpu_mul_arbiter.sv - scoreboard bench for fpu_mul_arbiter with a behavioural multiplier
module tb_fpu_mul_arbiter;
    localparam int WIDTH = 32;
    localparam int E     = 8;
    localparam int F     = 23;
    localparam int BIAS  = 127;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a = '0;
    logic [2*WIDTH-1:0] req_b = '0;
    logic               mul_start;
    logic               mul_busy;
    logic [WIDTH:0]     mul_a;
    logic [WIDTH:0]     mul_b;
    logic [E+F+1:0]     mul_r = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               res_id;
    logic               res_s;
    logic [E-1:0]       res_e;
    logic [F:0]         res_f;
    logic               res_err;

    typedef struct packed {
        logic         id;
        logic         s;
        logic [E-1:0] e;
        logic [F:0]   f;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_len = 3;
    bit   stuck = 1'b0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    fpu_mul_arbiter #(.WIDTH(WIDTH), .E(E), .F(F), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_start(mul_start), .mul_busy(mul_busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_s(res_s), .res_e(res_e), .res_f(res_f), .res_err(res_err)
    );

    function automatic logic [WIDTH:0] unpack_op(input logic [WIDTH-1:0] op);
        logic [E-1:0] ex;
        logic         hidden;
        ex     = op[WIDTH-2 -: E];
        hidden = (ex == '0) ? 1'b0 : 1'b1;
        return {op[WIDTH-1], ex, hidden, op[F-1:0]};
    endfunction

    function automatic logic [E+F+1:0] model_mul(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [2*F+1:0] m;
        logic [E-1:0]   ex;
        m  = a[F:0] * b[F:0];
        ex = a[WIDTH-1 -: E] + b[WIDTH-1 -: E] - E'(BIAS);
        return {a[WIDTH] ^ b[WIDTH], ex, m[2*F+1 -: F+1]};
    endfunction

    // Shared multiplier: busy for busy_len cycles after each start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (mul_start) begin
            busy_cnt <= busy_len;
            mul_r    <= model_mul(mul_a, mul_b);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mul_busy = stuck || (busy_cnt > 0);

    // Scoreboard push: expected result computed from the requester's own operands.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    exp_q.push_back({1'(i), model_mul(unpack_op(req_a[i*WIDTH +: WIDTH]),
                                                      unpack_op(req_b[i*WIDTH +: WIDTH]))});
                    grant_q.push_back(i);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b0;
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        grant_q.delete();
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        req_a = {32'h3F800000, 32'h40000000};
        req_b = {32'h3F800000, 32'h40000000};
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        n_tests++;
        if ({mul_start, mul_a, mul_b, res_valid, res_id, res_s, res_e, res_f, res_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b a=%h b=%h v=%b id=%b s=%b e=%h f=%h err=%b expected all 0",
                     mul_start, mul_a, mul_b, res_valid, res_id, res_s, res_e, res_f, res_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_basic();
        int   lat;
        exp_t ex;
        busy_len = 3;
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_a = {32'h0, 32'h3FC00000};
        req_b = {32'h0, 32'h40000000};
        req_valid = 2'b01;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (mul_start !== 1'b1 || mul_a !== {1'b0, 8'h7F, 1'b1, 23'h400000}) begin
            n_fail++;
            $display("FAIL basic_launch: got start=%b mul_a=%h expected start=1 mul_a=%h",
                     mul_start, mul_a, {1'b0, 8'h7F, 1'b1, 23'h400000});
        end
        @(negedge clk);
        n_tests++;
        if (mul_start !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start_pulse: got %b expected 0", mul_start);
        end
        lat = 2;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 6", lat);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL basic_result: got empty scoreboard expected one entry");
        end else begin
            ex = exp_q.pop_front();
            if ({res_id, res_s, res_e, res_f} !== ex || res_err !== 1'b0 || res_id !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_result: got id=%b s=%b e=%h f=%h err=%b expected id=%b s=%b e=%h f=%h err=0",
                         res_id, res_s, res_e, res_f, res_err, ex.id, ex.s, ex.e, ex.f);
            end
        end
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got res_valid=%b expected 0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        int   cnt;
        exp_t ex;
        do_reset();
        busy_len = 2;
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_a = {32'h40400000, 32'h3F800000};
        req_b = {32'h40800000, 32'hBF000000};
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!res_valid && cnt < 50);
            n_tests++;
            if (!res_valid || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rr_result%0d: got valid=%b queued=%0d expected a result", k, res_valid, exp_q.size());
            end else begin
                ex = exp_q.pop_front();
                if ({res_id, res_s, res_e, res_f} !== ex) begin
                    n_fail++;
                    $display("FAIL rr_result%0d: got id=%b s=%b e=%h f=%h expected id=%b s=%b e=%h f=%h",
                             k, res_id, res_s, res_e, res_f, ex.id, ex.s, ex.e, ex.f);
                end
            end
            if (k == 2) begin
                @(posedge clk);
                #1 req_valid = 2'b00;
            end
        end
        n_tests++;
        if (grant_q.size() != 3 || grant_q[0] != 0 || grant_q[1] != 1 || grant_q[2] != 0) begin
            n_fail++;
            $display("FAIL rr_order: got %0d grants %p expected 0,1,0", grant_q.size(), grant_q);
        end
        grant_q.delete();
    endtask

    task automatic test_hold_stall();
        int   cnt;
        exp_t ex;
        exp_t ex1;
        busy_len = 1;
        res_ready = 1'b0;
        @(posedge clk);
        #1 req_a = {32'h3F800000, 32'hC0A00000};
        req_b = {32'h40000000, 32'h41200000};
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b10;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!res_valid && cnt < 50);
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (res_valid !== 1'b1 || {res_id, res_s, res_e, res_f} !== ex || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b id=%b s=%b e=%h f=%h ready=%b expected v=1 id=%b s=%b e=%h f=%h ready=00",
                         c, res_valid, res_id, res_s, res_e, res_f, req_ready, ex.id, ex.s, ex.e, ex.f);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        n_tests++;
        if (req_ready !== 2'b00 || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_handshake: got ready=%b v=%b expected ready=00 v=1", req_ready, res_valid);
        end
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b0 || req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_idle_next: got v=%b ready=%b expected v=0 ready=10", res_valid, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!res_valid && cnt < 50);
        n_tests++;
        if (!res_valid || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_second: got valid=%b queued=%0d expected a result", res_valid, exp_q.size());
        end else begin
            ex1 = exp_q.pop_front();
            if ({res_id, res_s, res_e, res_f} !== ex1 || res_id !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_second: got id=%b s=%b e=%h f=%h expected id=%b s=%b e=%h f=%h",
                         res_id, res_s, res_e, res_f, ex1.id, ex1.s, ex1.e, ex1.f);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_denormal();
        int   cnt;
        exp_t ex;
        busy_len = 2;
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_a = {32'h0, 32'h00000001};
        req_b = {32'h0, 32'h3F800000};
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (mul_start !== 1'b1 || mul_a !== {1'b0, 8'h00, 1'b0, 23'h000001} || mul_b[F] !== 1'b1) begin
            n_fail++;
            $display("FAIL denorm_hidden: got start=%b mul_a=%h mul_b=%h expected start=1 mul_a=%h hidden_b=1",
                     mul_start, mul_a, mul_b, {1'b0, 8'h00, 1'b0, 23'h000001});
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!res_valid && cnt < 50);
        n_tests++;
        if (!res_valid || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL denorm_result: got valid=%b queued=%0d expected a result", res_valid, exp_q.size());
        end else begin
            ex = exp_q.pop_front();
            if ({res_id, res_s, res_e, res_f} !== ex) begin
                n_fail++;
                $display("FAIL denorm_result: got id=%b s=%b e=%h f=%h expected id=%b s=%b e=%h f=%h",
                         res_id, res_s, res_e, res_f, ex.id, ex.s, ex.e, ex.f);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        busy_len = 20;
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_a = {32'h0, 32'h40000000};
        req_b = {32'h0, 32'h40400000};
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, mul_start, mul_a, mul_b, res_valid, res_id, res_s, res_e, res_f, res_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b start=%b a=%h b=%h v=%b id=%b s=%b e=%h f=%h err=%b expected all 0",
                     req_ready, mul_start, mul_a, mul_b, res_valid, res_id, res_s, res_e, res_f, res_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        grant_q.delete();
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_discard: got res_valid=1 after release expected 0");
        end
        @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_pointer: got ready=%b expected 01", req_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 req_valid = 2'b00;
        rst_n = 1'b1;
        exp_q.delete();
        grant_q.delete();
    endtask

    task automatic test_timeout();
        int lat;
        stuck = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_a = {32'h3F800000, 32'h0};
        req_b = {32'h3F800000, 32'h0};
        req_valid = 2'b10;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
`ifdef FPU_MUL_ARB_TIMEOUT_EN
        lat = 1;
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected 10", lat);
        end
        n_tests++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_id !== 1'b1 || {res_s, res_e, res_f} !== '0) begin
            n_fail++;
            $display("FAIL timeout_result: got v=%b err=%b id=%b s=%b e=%h f=%h expected v=1 err=1 id=1 fields 0",
                     res_valid, res_err, res_id, res_s, res_e, res_f);
        end
        stuck = 1'b0;
        @(negedge clk);
        exp_q.delete();
`else
        lat = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || mul_start) lat++;
        end
        n_tests++;
        if (lat != 0 || res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: got %0d cycles with activity err=%b expected 0 and err=0", lat, res_err);
        end
        do_reset();
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold_stall();
        test_denormal();
        test_reset_in_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
